// File: rtl/rtype_pkg.sv
// rtype_pkg: opcode, funct and ALU encodings plus FSM state type for the R-type sequencer
package rtype_pkg;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_XOR    = 4'b0011;
    localparam logic [3:0] ALU_SLL    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_SLT    = 4'b0111;
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK, S_DONE} state_e;
endpackage

// File: rtl/rtype_decoder.sv
// rtype_decoder: splits an RV32 word into register fields and maps (funct7,funct3) to an ALU op
module rtype_decoder
    import rtype_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4
) (
    input  logic [31:0]           instr,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  legal
);
    logic [3:0] alu_sel;
    logic       funct_ok;

    always_comb begin
        alu_sel  = ALU_ADD;
        funct_ok = 1'b1;
        case ({instr[31:25], instr[14:12]})
            {F7_BASE, F3_ADD_SUB}: alu_sel = ALU_ADD;
            {F7_ALT,  F3_ADD_SUB}: alu_sel = ALU_SUB;
            {F7_BASE, F3_AND}:     alu_sel = ALU_AND;
            {F7_BASE, F3_OR}:      alu_sel = ALU_OR;
            {F7_BASE, F3_XOR}:     alu_sel = ALU_XOR;
            {F7_BASE, F3_SLL}:     alu_sel = ALU_SLL;
            {F7_BASE, F3_SRL}:     alu_sel = ALU_SRL;
            {F7_BASE, F3_SLT}:     alu_sel = ALU_SLT;
            default:               funct_ok = 1'b0;
        endcase
    end

    assign rs1         = REG_ADDR_W'(instr[19:15]);
    assign rs2         = REG_ADDR_W'(instr[24:20]);
    assign rd          = REG_ADDR_W'(instr[11:7]);
    assign alu_control = ALU_CTRL_W'(alu_sel);
    assign legal       = funct_ok && (instr[6:0] == OPC_RTYPE);
endmodule

// File: rtl/rtype_sequencer.sv
// rtype_sequencer: multi-cycle FSM that steps the register-file/ALU datapath through one
// R-type instruction at a time, with valid/ready handshakes on the instruction and done sides.
module rtype_sequencer
    import rtype_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [REG_ADDR_W-1:0] read_reg_num1,
    output logic [REG_ADDR_W-1:0] read_reg_num2,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  regwrite,
    input  logic                  zero_flag,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic                  zero_out,
    output logic                  illegal,
    output logic                  busy,
    output logic [CNT_W-1:0]      retired_count
);
    state_e                state_q, state_d;
    logic [31:0]           instr_q, instr_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [ALU_CTRL_W-1:0] alu_q, alu_d;
    logic                  illegal_q, illegal_d;
    logic                  zero_q, zero_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
    logic [ALU_CTRL_W-1:0] dec_alu;
    logic                  dec_legal;

    rtype_decoder #(
        .REG_ADDR_W(REG_ADDR_W),
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_dec (
        .instr      (instr_q),
        .rs1        (dec_rs1),
        .rs2        (dec_rs2),
        .rd         (dec_rd),
        .alu_control(dec_alu),
        .legal      (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        alu_d     = alu_q;
        illegal_d = illegal_q;
        zero_d    = zero_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: if (instr_valid) begin
                instr_d   = instr;
                illegal_d = 1'b0;
                zero_d    = 1'b0;
                state_d   = S_DECODE;
            end
            // Datapath fields load on the edge into EXECUTE and then hold until the next legal decode
            S_DECODE: if (dec_legal) begin
                rs1_d   = dec_rs1;
                rs2_d   = dec_rs2;
                rd_d    = dec_rd;
                alu_d   = dec_alu;
                state_d = S_EXECUTE;
            end else begin
                illegal_d = 1'b1;
                state_d   = S_DONE;
            end
            S_EXECUTE: state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                zero_d  = zero_flag;
                state_d = S_DONE;
            end
            S_DONE: if (done_ready) begin
                cnt_d   = illegal_q ? cnt_q : cnt_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            alu_q     <= '0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            alu_q     <= alu_d;
            illegal_q <= illegal_d;
            zero_q    <= zero_d;
            cnt_q     <= cnt_d;
        end
    end

    // Gated by reset so a write in flight is dropped in the same cycle reset rises
    assign regwrite      = (state_q == S_WRITEBACK) && (rd_q != '0) && !reset;
    assign instr_ready   = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done_valid    = (state_q == S_DONE);
    assign read_reg_num1 = rs1_q;
    assign read_reg_num2 = rs2_q;
    assign write_reg     = rd_q;
    assign alu_control   = alu_q;
    assign zero_out      = zero_q;
    assign illegal       = illegal_q;
    assign retired_count = cnt_q;
endmodule

// File: tb/tb_rtype_sequencer.sv
// tb_rtype_sequencer: directed vectors with hand-computed expectations for rtype_sequencer
module tb_rtype_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
    logic [3:0]  alu_control;
    logic        regwrite;
    logic        zero_flag = 1'b0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic        zero_out, illegal, busy;
    logic [15:0] retired_count;
    int          n_vec = 0;
    int          n_err = 0;
    int          edges, rw;

    rtype_sequencer dut (
        .clock(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
        .zero_flag(zero_flag), .done_valid(done_valid), .done_ready(done_ready),
        .zero_out(zero_out), .illegal(illegal), .busy(busy), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer w in IDLE, then count edges after the accept edge until done_valid (bounded)
    task automatic issue(input logic [31:0] w, output int n_edges, output int n_rw);
        instr = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr = 32'hFFFF_FFFF;
        n_edges = 0;
        n_rw = 0;
        while (!done_valid && n_edges < 10) begin
            tick();
            n_edges++;
            if (regwrite) n_rw++;
        end
    endtask

    task automatic retire();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done_valid, 0);
        check("rst_regwrite", regwrite, 0);
        check("rst_count", retired_count, 0);
        check("rst_alu", alu_control, 0);
        check("rst_illegal", illegal, 0);

        // ADD x3,x1,x2
        issue(32'h002081B3, edges, rw);
        check("add_latency", edges, 3);
        check("add_rw_cycles", rw, 1);
        check("add_rs1", read_reg_num1, 1);
        check("add_rs2", read_reg_num2, 2);
        check("add_rd", write_reg, 3);
        check("add_alu", alu_control, 4'b0010);
        check("add_illegal", illegal, 0);
        check("add_zero", zero_out, 0);
        check("add_regwrite_done", regwrite, 0);
        retire();
        check("add_count", retired_count, 1);
        check("add_idle", instr_ready, 1);
        check("add_done_clr", done_valid, 0);
        check("add_hold_rs1", read_reg_num1, 1);

        // SUB x5,x1,x1 with zero result
        zero_flag = 1'b1;
        issue(32'h401082B3, edges, rw);
        zero_flag = 1'b0;
        check("sub_latency", edges, 3);
        check("sub_alu", alu_control, 4'b0110);
        check("sub_rd", write_reg, 5);
        check("sub_zero", zero_out, 1);
        check("sub_illegal", illegal, 0);
        retire();
        check("sub_count", retired_count, 2);

        // ADDI is not R-type
        issue(32'h00108093, edges, rw);
        check("addi_latency", edges, 1);
        check("addi_rw", rw, 0);
        check("addi_illegal", illegal, 1);
        check("addi_hold_alu", alu_control, 4'b0110);
        check("addi_hold_rd", write_reg, 5);
        retire();
        check("addi_count", retired_count, 2);

        // funct7=0x20 with funct3=SLL is not in the table
        issue(32'h401091B3, edges, rw);
        check("badf_latency", edges, 1);
        check("badf_illegal", illegal, 1);
        check("badf_rw", rw, 0);
        retire();
        check("badf_count", retired_count, 2);

        // ADD x0,x1,x2: full sequence, write suppressed
        issue(32'h00208033, edges, rw);
        check("x0_latency", edges, 3);
        check("x0_rw", rw, 0);
        check("x0_rd", write_reg, 0);
        retire();
        check("x0_count", retired_count, 3);

        // SRL x3,x1,x2
        issue(32'h0020D1B3, edges, rw);
        check("srl_alu", alu_control, 4'b0101);
        retire();
        check("srl_count", retired_count, 4);

        // XOR x3,x1,x2 then hold done_ready low with a competing instruction offered
        zero_flag = 1'b1;
        issue(32'h0020C1B3, edges, rw);
        zero_flag = 1'b0;
        check("xor_alu", alu_control, 4'b0011);
        instr_valid = 1'b1;
        instr = 32'h002081B3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_done", done_valid, 1);
            check("bp_zero", zero_out, 1);
            check("bp_ready", instr_ready, 0);
        end
        instr_valid = 1'b0;
        retire();
        check("bp_count", retired_count, 5);
        tick();
        check("bp_not_taken", busy, 0);

        // Reset in EXECUTE
        instr = 32'h002081B3;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("exe_regwrite", regwrite, 0);
        check("exe_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rexe_busy", busy, 0);
        check("rexe_ready", instr_ready, 1);
        check("rexe_regwrite", regwrite, 0);
        check("rexe_done", done_valid, 0);
        check("rexe_count", retired_count, 0);

        // Reset in WRITEBACK drops regwrite within the cycle
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        check("wb_regwrite", regwrite, 1);
        reset = 1'b1;
        #1;
        check("rwb_regwrite_now", regwrite, 0);
        tick();
        reset = 1'b0;
        check("rwb_busy", busy, 0);
        check("rwb_done", done_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
